sh_hf_recv_adaptor_n: RTL and testbench
=======================================

SH_HF_RECV_ADAPTOR_N -- requirements
Module: sh_hf_recv_adaptor_n

Interface
REQ-001 SHALL have parameter DW, default 32, data word width.
REQ-002 SHALL have parameter DEPTH, default 16, FIFO depth in words; power of 2, at least 4.
REQ-003 SHALL have parameter TURN_W, default 2, LSAB turn bus width.
REQ-004 SHALL have parameter MY_TURN, default 0, turn value granting this adaptor the LSAB.
REQ-005 SHALL have parameter LEN_W, default 12, packet word-count width.
REQ-006 SHALL have port CLK  in  1  single clock; all logic on rising edge.
REQ-007 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-008 SHALL have port LSAB_TURN  in  TURN_W  current LSAB slot owner.
REQ-009 SHALL have port DATA_FROM_ETH  in  DW  received word from MAC.
REQ-010 SHALL have port WRITE_IN  in  1  DATA_FROM_ETH valid this cycle.
REQ-011 SHALL have port NEW_PCKT  in  1  packet-end status, 1 = good, 0 = bad; sampled only with NEW_PCKT_VALID.
REQ-012 SHALL have port NEW_PCKT_VALID  in  1  one-cycle packet-end strobe.
REQ-013 SHALL have port OVF_ACK  in  1  clears OVERFLOW.
REQ-014 SHALL have port DATA_OUT  out  DW  word to LSAB.
REQ-015 SHALL have port WRITE  out  1  DATA_OUT valid, write into LSAB.
REQ-016 SHALL have port IRQ  out  1  packet status (1 = good); meaningful only with IRQ_VLD.
REQ-017 SHALL have port IRQ_VLD  out  1  one-cycle packet-complete strobe.
REQ-018 SHALL have port IRQ_LEN  out  LEN_W  word count of the reported packet.
REQ-019 SHALL have port OVERFLOW  out  1  sticky loss indicator.

Function
REQ-020 SHALL push DATA_FROM_ETH when WRITE_IN=1 and the registered FIFO count < DEPTH.
REQ-021 SHALL drop the word when WRITE_IN=1 and the count = DEPTH, even if a pop occurs the same cycle, and SHALL set OVERFLOW.
REQ-022 SHALL pop one word per cycle when LSAB_TURN==MY_TURN and the FIFO is non-empty; no pops otherwise.
REQ-023 SHALL register DATA_OUT and assert WRITE for exactly the cycle after each pop; latency is 1 cycle from grant to WRITE.
REQ-024 SHALL allow a push and a pop in the same cycle when not full; count unchanged.
REQ-025 SHALL count accepted words of the open packet in an input counter that saturates at 2^LEN_W-1; saturation sets OVERFLOW.
REQ-026 SHALL, on NEW_PCKT_VALID=1, close the packet: latch {count, NEW_PCKT} into the pending descriptor and zero the input counter. A word accepted in the same cycle SHALL count toward the closing packet.
REQ-027 SHALL have a drain FSM with states IDLE, DRAIN and NOTIFY.
  - IDLE -> DRAIN when a descriptor is pending.
  - DRAIN -> NOTIFY when the drained-word counter equals the descriptor length and the last WRITE has been issued.
  - NOTIFY -> IDLE after one cycle.
REQ-028 SHALL, in NOTIFY, pulse IRQ_VLD for one cycle with IRQ = latched status and IRQ_LEN = latched length.
REQ-029 SHALL treat a zero-length close as pending and go directly to NOTIFY with IRQ_LEN=0.
REQ-030 SHALL hold one pending descriptor only; a close while one is pending and not yet in NOTIFY SHALL be discarded and SHALL set OVERFLOW.
REQ-031 SHALL continue popping words of the next open packet during DRAIN/NOTIFY; the drained-word counter tracks only the descriptor's words.
REQ-032 SHALL clear OVERFLOW on OVF_ACK; if a set event and OVF_ACK coincide, set SHALL win.
REQ-033 SHALL wrap FIFO pointers modulo DEPTH, using log2(DEPTH)+1-bit count arithmetic.

Reset
REQ-034 SHALL, on RST=1 at a clock edge, empty the FIFO, zero all counters, clear the descriptor and enter IDLE.
REQ-035 SHALL drive DATA_OUT=0, WRITE=0, IRQ=0, IRQ_VLD=0, IRQ_LEN=0 and OVERFLOW=0 out of reset; RST mid-packet SHALL discard it silently with no IRQ_VLD.

Structure
REQ-036 SHALL take FSM state encoding and the clog2 helper from shared package sh_hf_pkg.
REQ-037 SHALL instantiate the FIFO as sub-module sh_hf_sync_fifo (parameters DW, DEPTH; push/pop/full/empty/count).

Verification
REQ-038 SHALL cover: 5 words, NEW_PCKT_VALID with NEW_PCKT=1, LSAB_TURN=MY_TURN held -> 5 WRITEs, then IRQ_VLD=1, IRQ=1, IRQ_LEN=5.
REQ-039 SHALL cover: 20 back-to-back words, DEPTH=16, no turn -> 16 stored, OVERFLOW=1; after OVF_ACK -> OVERFLOW=0.
REQ-040 SHALL cover: LSAB_TURN toggling MY_TURN/other every 2 cycles -> WRITE only in cycles following granted cycles, data order preserved.
REQ-041 SHALL cover: close with NEW_PCKT=0 after 3 words -> IRQ_VLD with IRQ=0, IRQ_LEN=3.
REQ-042 SHALL cover: second close while first pending (no turn) -> OVERFLOW=1, only one IRQ_VLD once drained.
REQ-043 SHALL cover: RST after 4 words mid-packet -> WRITE=0, FIFO empty, no IRQ_VLD thereafter.

Source files
------------

// File: rtl/sh_hf_pkg.sv
// sh_hf_pkg: shared drain-FSM state encoding and the clog2 helper.
package sh_hf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_NOTIFY = 2'd2
    } drain_st_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sh_hf_sync_fifo.sv
// sh_hf_sync_fifo: single-clock FIFO with show-ahead read data.
// Ports: clk_i/rst_i (sync, active-high); push_i+data_i write; pop_i
// consumes data_o; full_o/empty_o/count_o reflect the registered fill level.
// A push while full or a pop while empty is ignored.
module sh_hf_sync_fifo
    import sh_hf_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/sh_hf_recv_adaptor_n.sv
// sh_hf_recv_adaptor_n: buffers MAC receive words and forwards them to the LSAB.
// Ports: CLK/RST (sync, active-high); DATA_FROM_ETH+WRITE_IN word input;
// NEW_PCKT_VALID/NEW_PCKT packet end + status; LSAB_TURN grants popping when
// equal to MY_TURN; DATA_OUT+WRITE registered LSAB write; IRQ_VLD/IRQ/IRQ_LEN
// per-packet completion report; OVERFLOW sticky loss flag cleared by OVF_ACK.
module sh_hf_recv_adaptor_n
    import sh_hf_pkg::*;
#(
    parameter int DW      = 32,
    parameter int DEPTH   = 16,
    parameter int TURN_W  = 2,
    parameter int MY_TURN = 0,
    parameter int LEN_W   = 12
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [TURN_W-1:0] LSAB_TURN,
    input  logic [DW-1:0]     DATA_FROM_ETH,
    input  logic              WRITE_IN,
    input  logic              NEW_PCKT,
    input  logic              NEW_PCKT_VALID,
    input  logic              OVF_ACK,
    output logic [DW-1:0]     DATA_OUT,
    output logic              WRITE,
    output logic              IRQ,
    output logic              IRQ_VLD,
    output logic [LEN_W-1:0]  IRQ_LEN,
    output logic              OVERFLOW
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0]    fifo_dout, dout_q;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_cnt;
    logic             accept, drop, pop, sat, close_ok, head_pop, to_notify, ovf_set;
    logic             write_q, ovf_q, ovf_d;
    logic             pend_q, pend_d, pend_st_q, pend_st_d;
    logic [LEN_W-1:0] in_cnt_q, in_cnt_d, close_len;
    logic [LEN_W-1:0] pend_len_q, pend_len_d, drn_q, drn_d, xtra_q, xtra_d;
    logic             irq_q, irq_vld_q;
    logic [LEN_W-1:0] irq_len_q;
    drain_st_e        state_q;

    sh_hf_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (accept),
        .data_i  (DATA_FROM_ETH),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign accept    = WRITE_IN && !fifo_full;
    assign drop      = WRITE_IN && (fifo_cnt == CW'(DEPTH));
    assign pop       = (LSAB_TURN == TURN_W'(MY_TURN)) && !fifo_empty;
    assign sat       = &in_cnt_q;
    assign close_len = in_cnt_q + LEN_W'(accept && !sat);
    // The single descriptor slot frees up in NOTIFY, so a close landing there is kept.
    assign close_ok  = NEW_PCKT_VALID && (!pend_q || state_q == ST_NOTIFY);
    assign ovf_set   = drop || (accept && sat) || (NEW_PCKT_VALID && !close_ok);
    // Pops beyond the descriptor length belong to the following packet.
    assign head_pop  = !pend_q || (drn_q < pend_len_q);
    assign to_notify = (state_q == ST_IDLE && pend_q && pend_len_q == '0) ||
                       (state_q == ST_DRAIN && drn_q >= pend_len_q);

    always_comb begin
        in_cnt_d   = NEW_PCKT_VALID ? '0 : in_cnt_q + LEN_W'(accept && !sat);
        pend_d     = close_ok || (pend_q && state_q != ST_NOTIFY);
        pend_len_d = close_ok ? close_len : pend_len_q;
        pend_st_d  = close_ok ? NEW_PCKT : pend_st_q;
        drn_d      = (state_q == ST_NOTIFY) ? xtra_q + LEN_W'(pop) : drn_q + LEN_W'(pop && head_pop);
        xtra_d     = (state_q == ST_NOTIFY) ? '0 : xtra_q + LEN_W'(pop && !head_pop);
        ovf_d      = ovf_set || (ovf_q && !OVF_ACK);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dout_q     <= '0;
            write_q    <= 1'b0;
            ovf_q      <= 1'b0;
            in_cnt_q   <= '0;
            pend_q     <= 1'b0;
            pend_st_q  <= 1'b0;
            pend_len_q <= '0;
            drn_q      <= '0;
            xtra_q     <= '0;
        end else begin
            if (pop) dout_q <= fifo_dout;
            write_q    <= pop;
            ovf_q      <= ovf_d;
            in_cnt_q   <= in_cnt_d;
            pend_q     <= pend_d;
            pend_st_q  <= pend_st_d;
            pend_len_q <= pend_len_d;
            drn_q      <= drn_d;
            xtra_q     <= xtra_d;
        end
    end

    // Drain FSM; IRQ outputs are loaded on entry to NOTIFY so IRQ_VLD
    // is high for exactly the NOTIFY cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            irq_q     <= 1'b0;
            irq_vld_q <= 1'b0;
            irq_len_q <= '0;
        end else begin
            irq_vld_q <= to_notify;
            if (to_notify) begin
                irq_q     <= pend_st_q;
                irq_len_q <= pend_len_q;
            end
            case (state_q)
                ST_IDLE:  state_q <= to_notify ? ST_NOTIFY : (pend_q ? ST_DRAIN : ST_IDLE);
                ST_DRAIN: state_q <= to_notify ? ST_NOTIFY : ST_DRAIN;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign DATA_OUT = dout_q;
    assign WRITE    = write_q;
    assign IRQ      = irq_q;
    assign IRQ_VLD  = irq_vld_q;
    assign IRQ_LEN  = irq_len_q;
    assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_sh_hf_recv_adaptor_n.sv
// tb_sh_hf_recv_adaptor_n: directed self-checking bench for sh_hf_recv_adaptor_n.
module tb_sh_hf_recv_adaptor_n;

    localparam int DW     = 32;
    localparam int DEPTH  = 16;
    localparam int TURN_W = 2;
    localparam int LEN_W  = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [TURN_W-1:0] turn = '0;
    logic [DW-1:0]     din = '0;
    logic              wr_in = 1'b0;
    logic              pk = 1'b0;
    logic              pk_vld = 1'b0;
    logic              ack = 1'b0;
    logic [DW-1:0]     dout;
    logic              wr, irq, irq_vld, ovf;
    logic [LEN_W-1:0]  irq_len;

    int                checks = 0;
    int                errs = 0;
    logic [DW-1:0]     wq[$];
    int                irq_n = 0;
    logic              irq_s = 1'b0;
    logic [LEN_W-1:0]  irq_l = '0;

    always #5 clk = ~clk;

    sh_hf_recv_adaptor_n #(
        .DW(DW), .DEPTH(DEPTH), .TURN_W(TURN_W), .MY_TURN(0), .LEN_W(LEN_W)
    ) dut (
        .CLK(clk), .RST(rst), .LSAB_TURN(turn), .DATA_FROM_ETH(din),
        .WRITE_IN(wr_in), .NEW_PCKT(pk), .NEW_PCKT_VALID(pk_vld), .OVF_ACK(ack),
        .DATA_OUT(dout), .WRITE(wr), .IRQ(irq), .IRQ_VLD(irq_vld),
        .IRQ_LEN(irq_len), .OVERFLOW(ovf)
    );

    always @(negedge clk) begin
        if (wr) wq.push_back(dout);
        if (irq_vld) begin
            irq_n++;
            irq_s = irq;
            irq_l = irq_len;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic word(input logic [DW-1:0] d, input logic cl, input logic st);
        din = d;
        wr_in = 1'b1;
        pk_vld = cl;
        pk = st;
        tick(1);
        wr_in = 1'b0;
        pk_vld = 1'b0;
    endtask

    task automatic close(input logic st);
        pk_vld = 1'b1;
        pk = st;
        tick(1);
        pk_vld = 1'b0;
    endtask

    task automatic chk_words(input string tag, input int n, input logic [DW-1:0] base);
        chk({tag, "_cnt"}, 64'(wq.size()), 64'(n));
        for (int i = 0; i < n; i++)
            chk(tag, (i < wq.size()) ? 64'(wq[i]) : 64'hx, 64'(base + DW'(i)));
    endtask

    task automatic chk_irq(input string tag, input int n, input logic st, input int len);
        chk({tag, "_n"}, 64'(irq_n), 64'(n));
        chk({tag, "_st"}, 64'(irq_s), 64'(st));
        chk({tag, "_len"}, 64'(irq_l), 64'(len));
    endtask

    initial begin
        int rem;
        logic g;
        tick(2);
        chk("rst_dout", 64'(dout), 64'h0);
        chk("rst_write", 64'(wr), 64'h0);
        chk("rst_irq", 64'(irq), 64'h0);
        chk("rst_irqvld", 64'(irq_vld), 64'h0);
        chk("rst_irqlen", 64'(irq_len), 64'h0);
        chk("rst_ovf", 64'(ovf), 64'h0);
        rst = 1'b0;
        tick(1);

        // Five good words streamed with the turn held.
        turn = 2'd0; wq.delete(); irq_n = 0;
        for (int i = 0; i < 5; i++) word(32'hA0 + 32'(i), i == 4, 1'b1);
        tick(10);
        chk_words("t1_data", 5, 32'hA0);
        chk_irq("t1_irq", 1, 1'b1, 5);

        // Bad packet of three words.
        wq.delete(); irq_n = 0;
        for (int i = 0; i < 3; i++) word(32'hB0 + 32'(i), i == 2, 1'b0);
        tick(10);
        chk_words("t2_data", 3, 32'hB0);
        chk_irq("t2_irq", 1, 1'b0, 3);

        // Zero-length close.
        irq_n = 0; irq_l = '1;
        close(1'b1);
        tick(6);
        chk_irq("t0_irq", 1, 1'b1, 0);

        // Turn toggles every two cycles; WRITE follows each granted cycle.
        turn = 2'd1; wq.delete(); irq_n = 0;
        for (int i = 0; i < 6; i++) word(32'hC0 + 32'(i), 1'b0, 1'b0);
        rem = 6;
        for (int k = 0; k < 16; k++) begin
            g = ((k / 2) % 2) == 0;
            turn = g ? 2'd0 : 2'd1;
            tick(1);
            chk("t3_write", 64'(wr), 64'(g && rem > 0));
            if (g && rem > 0) rem--;
        end
        chk_words("t3_data", 6, 32'hC0);
        close(1'b1);
        tick(6);
        chk_irq("t3_irq", 1, 1'b1, 6);

        // Twenty words without the turn: sixteen kept, overflow set; ack on the
        // final dropped word must lose to the set.
        turn = 2'd1; wq.delete(); irq_n = 0;
        for (int i = 0; i < 20; i++) begin
            ack = (i == 19);
            word(32'hD00 + 32'(i), 1'b0, 1'b0);
            if (i == 15) chk("t5_ovf_full", 64'(ovf), 64'h0);
        end
        ack = 1'b0;
        chk("t5_ovf_set", 64'(ovf), 64'h1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("t5_ovf_ack", 64'(ovf), 64'h0);
        close(1'b1);
        turn = 2'd0;
        tick(24);
        chk_words("t5_data", 16, 32'hD00);
        chk_irq("t5_irq", 1, 1'b1, 16);

        // Second close while the first is pending is discarded.
        turn = 2'd1; wq.delete(); irq_n = 0;
        word(32'hE0, 1'b0, 1'b0);
        word(32'hE1, 1'b1, 1'b1);
        chk("t4_ovf_pre", 64'(ovf), 64'h0);
        word(32'hE2, 1'b1, 1'b0);
        chk("t4_ovf", 64'(ovf), 64'h1);
        turn = 2'd0;
        tick(12);
        chk_words("t4_data", 3, 32'hE0);
        chk_irq("t4_irq", 1, 1'b1, 2);

        // Reset mid-packet discards everything silently.
        turn = 2'd1; irq_n = 0;
        for (int i = 0; i < 4; i++) word(32'hF0 + 32'(i), 1'b0, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        turn = 2'd0;
        wq.delete();
        chk("t6_write", 64'(wr), 64'h0);
        chk("t6_ovf", 64'(ovf), 64'h0);
        tick(10);
        chk("t6_nowrite", 64'(wq.size()), 64'h0);
        chk("t6_noirq", 64'(irq_n), 64'h0);
        word(32'h77, 1'b1, 1'b1);
        tick(8);
        chk_words("t6_data", 1, 32'h77);
        chk_irq("t6_irq", 1, 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
